// File: rtl/aurora_hls_nfc_pkg.sv
// Shared types and helpers for the Aurora native-flow-control generator.
package aurora_hls_nfc_pkg;

  typedef enum logic [1:0] {
    FLOWING   = 2'd0,
    SEND_XOFF = 2'd1,
    PAUSED    = 2'd2,
    SEND_XON  = 2'd3
  } nfc_state_e;

  localparam int NFC_MAX_WIDTH = 64;

  // XOFF is all ones across the NFC word; callers truncate to their width.
  function automatic logic [NFC_MAX_WIDTH-1:0] xoff_code(input int width);
    logic [NFC_MAX_WIDTH-1:0] ones;
    ones = '1;
    return ones >> (NFC_MAX_WIDTH - width);
  endfunction

  // XON is all zeros regardless of width.
  function automatic logic [NFC_MAX_WIDTH-1:0] xon_code(input int width);
    logic [NFC_MAX_WIDTH-1:0] zeros;
    zeros = '0;
    return zeros & {NFC_MAX_WIDTH{width >= 0}};
  endfunction

endpackage

// File: rtl/aurora_hls_nfc_latency.sv
// Stop-latency measurement: counts rx_tvalid beats that still arrive after
// XOFF was accepted, until the first idle cycle or until XON is accepted.
module aurora_hls_nfc_latency #(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     open_i,
  input  logic                     close_i,
  input  logic                     rx_tvalid,
  output logic [COUNTER_WIDTH-1:0] latency_count,
  output logic [COUNTER_WIDTH-1:0] latency_max
);

  logic                     active_q, active_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNTER_WIDTH-1:0] lat_q, lat_d;
  logic [COUNTER_WIDTH-1:0] max_q, max_d;
  logic [COUNTER_WIDTH-1:0] cnt_inc;
  logic [COUNTER_WIDTH-1:0] cnt_final;

  // Window bookkeeping: saturating beat count, capture and max on close.
  always_comb begin
    active_d  = active_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    max_d     = max_q;
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + COUNTER_WIDTH'(1);
    cnt_final = rx_tvalid ? cnt_inc : cnt_q;
    if (active_q) begin
      if (!rx_tvalid || close_i) begin
        active_d = 1'b0;
        lat_d    = cnt_final;
        if (cnt_final > max_q) max_d = cnt_final;
      end else begin
        cnt_d = cnt_inc;
      end
    end
    if (open_i) begin
      active_d = 1'b1;
      cnt_d    = '0;
    end
  end

  // Window state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      lat_q    <= '0;
      max_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
      max_q    <= max_d;
    end
  end

  assign latency_count = lat_q;
  assign latency_max   = max_q;

endmodule

// File: rtl/aurora_hls_nfc_ctrl.sv
// Hysteresis-based NFC generator: XOFF when the RX FIFO fills, periodic XOFF
// re-send while paused, XON when it drains, plus host statistics.
module aurora_hls_nfc_ctrl #(
  parameter int LEVEL_WIDTH         = 10,
  parameter int XOFF_THRESHOLD      = 384,
  parameter int XON_THRESHOLD       = 128,
  parameter int NFC_WIDTH           = 16,
  parameter int RETRANSMIT_INTERVAL = 256,
  parameter int COUNTER_WIDTH       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [LEVEL_WIDTH-1:0]   fifo_rx_level,
  input  logic                     rx_tvalid,
  input  logic                     s_axi_nfc_tready,
  output logic                     s_axi_nfc_tvalid,
  output logic [NFC_WIDTH-1:0]     s_axi_nfc_tdata,
  output logic                     paused,
  output logic [COUNTER_WIDTH-1:0] full_trigger_count,
  output logic [COUNTER_WIDTH-1:0] empty_trigger_count,
  output logic [COUNTER_WIDTH-1:0] retransmit_count,
  output logic [COUNTER_WIDTH-1:0] latency_count,
  output logic [COUNTER_WIDTH-1:0] latency_max
);

  import aurora_hls_nfc_pkg::*;

  localparam int TIMER_W = (RETRANSMIT_INTERVAL > 1) ? $clog2(RETRANSMIT_INTERVAL) : 1;
  localparam logic [TIMER_W-1:0] RETX_LAST =
    TIMER_W'((RETRANSMIT_INTERVAL > 0) ? RETRANSMIT_INTERVAL - 1 : 0);
  localparam bit RETX_EN = (RETRANSMIT_INTERVAL != 0);
  localparam logic [LEVEL_WIDTH-1:0] XOFF_LVL = LEVEL_WIDTH'(XOFF_THRESHOLD);
  localparam logic [LEVEL_WIDTH-1:0] XON_LVL  = LEVEL_WIDTH'(XON_THRESHOLD);
  localparam logic [NFC_WIDTH-1:0] XOFF_CODE = NFC_WIDTH'(xoff_code(NFC_WIDTH));
  localparam logic [NFC_WIDTH-1:0] XON_CODE  = NFC_WIDTH'(xon_code(NFC_WIDTH));

  nfc_state_e               state_q, state_d;
  logic                     tvalid_q, tvalid_d;
  logic [NFC_WIDTH-1:0]     tdata_q, tdata_d;
  logic                     retx_q, retx_d;
  logic [TIMER_W-1:0]       timer_q, timer_d;
  logic [COUNTER_WIDTH-1:0] full_q, full_d;
  logic [COUNTER_WIDTH-1:0] empty_q, empty_d;
  logic [COUNTER_WIDTH-1:0] retx_cnt_q, retx_cnt_d;
  logic                     handshake;
  logic                     lat_open;
  logic                     lat_close;

  assign handshake = tvalid_q && s_axi_nfc_tready;

  // Next-state, retransmit timer, statistics and registered message outputs.
  always_comb begin
    state_d    = state_q;
    retx_d     = retx_q;
    timer_d    = timer_q;
    full_d     = full_q;
    empty_d    = empty_q;
    retx_cnt_d = retx_cnt_q;
    lat_open   = 1'b0;
    lat_close  = 1'b0;
    unique case (state_q)
      FLOWING: begin
        if (enable && fifo_rx_level >= XOFF_LVL) begin
          state_d = SEND_XOFF;
          retx_d  = 1'b0;
        end
      end
      SEND_XOFF: begin
        if (handshake) begin
          state_d = PAUSED;
          timer_d = '0;
          if (retx_q) begin
            retx_cnt_d = retx_cnt_q + COUNTER_WIDTH'(1);
          end else begin
            full_d   = full_q + COUNTER_WIDTH'(1);
            lat_open = 1'b1;
          end
        end
      end
      PAUSED: begin
        timer_d = timer_q + TIMER_W'(1);
        if (fifo_rx_level <= XON_LVL || !enable) begin
          state_d = SEND_XON;
        end else if (RETX_EN && timer_q == RETX_LAST) begin
          state_d = SEND_XOFF;
          retx_d  = 1'b1;
        end
      end
      SEND_XON: begin
        if (handshake) begin
          state_d   = FLOWING;
          empty_d   = empty_q + COUNTER_WIDTH'(1);
          lat_close = 1'b1;
        end
      end
      default: state_d = FLOWING;
    endcase
    tvalid_d = (state_d == SEND_XOFF) || (state_d == SEND_XON);
    tdata_d  = tdata_q;
    if (state_d == SEND_XOFF) tdata_d = XOFF_CODE;
    else if (state_d == SEND_XON) tdata_d = XON_CODE;
  end

  // State and statistics registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FLOWING;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      retx_q     <= 1'b0;
      timer_q    <= '0;
      full_q     <= '0;
      empty_q    <= '0;
      retx_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      retx_q     <= retx_d;
      timer_q    <= timer_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      retx_cnt_q <= retx_cnt_d;
    end
  end

  aurora_hls_nfc_latency #(
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_latency (
    .clk          (clk),
    .rst          (rst),
    .open_i       (lat_open),
    .close_i      (lat_close),
    .rx_tvalid    (rx_tvalid),
    .latency_count(latency_count),
    .latency_max  (latency_max)
  );

  assign s_axi_nfc_tvalid    = tvalid_q;
  assign s_axi_nfc_tdata     = tdata_q;
  assign paused              = (state_q == PAUSED) || (state_q == SEND_XON);
  assign full_trigger_count  = full_q;
  assign empty_trigger_count = empty_q;
  assign retransmit_count    = retx_cnt_q;

endmodule

// File: tb/tb_aurora_hls_nfc_ctrl.sv
// Directed self-checking bench for the NFC generator (retransmit interval 8).
module tb_aurora_hls_nfc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [9:0]  fifo_rx_level = '0;
  logic        rx_tvalid = 1'b0;
  logic        s_axi_nfc_tready = 1'b0;
  logic        s_axi_nfc_tvalid;
  logic [15:0] s_axi_nfc_tdata;
  logic        paused;
  logic [31:0] full_trigger_count;
  logic [31:0] empty_trigger_count;
  logic [31:0] retransmit_count;
  logic [31:0] latency_count;
  logic [31:0] latency_max;

  int passCount = 0;
  int checkCount = 0;

  aurora_hls_nfc_ctrl #(
    .LEVEL_WIDTH(10), .XOFF_THRESHOLD(384), .XON_THRESHOLD(128),
    .NFC_WIDTH(16), .RETRANSMIT_INTERVAL(8), .COUNTER_WIDTH(32)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .fifo_rx_level      (fifo_rx_level),
    .rx_tvalid          (rx_tvalid),
    .s_axi_nfc_tready   (s_axi_nfc_tready),
    .s_axi_nfc_tvalid   (s_axi_nfc_tvalid),
    .s_axi_nfc_tdata    (s_axi_nfc_tdata),
    .paused             (paused),
    .full_trigger_count (full_trigger_count),
    .empty_trigger_count(empty_trigger_count),
    .retransmit_count   (retransmit_count),
    .latency_count      (latency_count),
    .latency_max        (latency_max)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [9:0] lvl, input logic en,
                               input logic rxv, input logic rdy);
    fifo_rx_level    = lvl;
    enable           = en;
    rx_tvalid        = rxv;
    s_axi_nfc_tready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Directed test sequence.
  initial begin
    // Reset behaviour and first XOFF held while tready stays low.
    applyStimulus(10'd500, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick(2);
    checkOutput("rst_tvalid", 64'(s_axi_nfc_tvalid), 64'd0);
    checkOutput("rst_tdata", 64'(s_axi_nfc_tdata), 64'd0);
    checkOutput("rst_paused", 64'(paused), 64'd0);
    checkOutput("rst_full", 64'(full_trigger_count), 64'd0);
    checkOutput("rst_empty", 64'(empty_trigger_count), 64'd0);
    checkOutput("rst_retx", 64'(retransmit_count), 64'd0);
    checkOutput("rst_lat", 64'(latency_count), 64'd0);
    checkOutput("rst_latmax", 64'(latency_max), 64'd0);
    rst = 1'b0;
    checkOutput("rel_tvalid_c1", 64'(s_axi_nfc_tvalid), 64'd0);
    tick(1);
    checkOutput("rel_tvalid_c2", 64'(s_axi_nfc_tvalid), 64'd1);
    checkOutput("rel_tdata_c2", 64'(s_axi_nfc_tdata), 64'hFFFF);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("hold_tvalid", 64'(s_axi_nfc_tvalid), 64'd1);
      checkOutput("hold_tdata", 64'(s_axi_nfc_tdata), 64'hFFFF);
    end
    s_axi_nfc_tready = 1'b1;
    tick(1);
    checkOutput("t1_tvalid_after_hs", 64'(s_axi_nfc_tvalid), 64'd0);
    checkOutput("t1_full", 64'(full_trigger_count), 64'd1);
    checkOutput("t1_paused", 64'(paused), 64'd1);

    // Hysteresis: 383 idle, 384 XOFF, 200 silent, 128 XON.
    applyStimulus(10'd383, 1'b1, 1'b0, 1'b1);
    doReset();
    tick(3);
    checkOutput("t2_383_tvalid", 64'(s_axi_nfc_tvalid), 64'd0);
    fifo_rx_level = 10'd384;
    tick(1);
    checkOutput("t2_384_tvalid", 64'(s_axi_nfc_tvalid), 64'd1);
    checkOutput("t2_384_tdata", 64'(s_axi_nfc_tdata), 64'hFFFF);
    tick(1);
    checkOutput("t2_full", 64'(full_trigger_count), 64'd1);
    fifo_rx_level = 10'd200;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checkOutput("t2_200_tvalid", 64'(s_axi_nfc_tvalid), 64'd0);
      checkOutput("t2_200_paused", 64'(paused), 64'd1);
    end
    fifo_rx_level = 10'd128;
    tick(1);
    checkOutput("t2_xon_tvalid", 64'(s_axi_nfc_tvalid), 64'd1);
    checkOutput("t2_xon_tdata", 64'(s_axi_nfc_tdata), 64'h0000);
    tick(1);
    checkOutput("t2_empty", 64'(empty_trigger_count), 64'd1);
    checkOutput("t2_paused_off", 64'(paused), 64'd0);
    tick(1);
    checkOutput("t2_full_final", 64'(full_trigger_count), 64'd1);

    // Retransmission every 9 cycles with level held high.
    applyStimulus(10'd400, 1'b1, 1'b0, 1'b1);
    doReset();
    tick(2);
    checkOutput("t3_full", 64'(full_trigger_count), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      tick(7);
      checkOutput("t3_quiet", 64'(s_axi_nfc_tvalid), 64'd0);
      tick(1);
      checkOutput("t3_resend_tvalid", 64'(s_axi_nfc_tvalid), 64'd1);
      checkOutput("t3_resend_tdata", 64'(s_axi_nfc_tdata), 64'hFFFF);
      tick(1);
      checkOutput("t3_retx", 64'(retransmit_count), 64'(k));
    end
    checkOutput("t3_full_final", 64'(full_trigger_count), 64'd1);

    // Stop latency: 20-beat episode, then a 5-beat episode.
    applyStimulus(10'd400, 1'b1, 1'b0, 1'b1);
    doReset();
    tick(2);
    s_axi_nfc_tready = 1'b0;
    rx_tvalid = 1'b1;
    tick(20);
    checkOutput("t4_lat_open", 64'(latency_count), 64'd0);
    rx_tvalid = 1'b0;
    tick(1);
    checkOutput("t4_lat20", 64'(latency_count), 64'd20);
    checkOutput("t4_max20", 64'(latency_max), 64'd20);
    applyStimulus(10'd100, 1'b1, 1'b0, 1'b1);
    tick(3);
    checkOutput("t4_empty", 64'(empty_trigger_count), 64'd1);
    checkOutput("t4_retx", 64'(retransmit_count), 64'd1);
    fifo_rx_level = 10'd400;
    tick(2);
    checkOutput("t4_full2", 64'(full_trigger_count), 64'd2);
    s_axi_nfc_tready = 1'b0;
    rx_tvalid = 1'b1;
    tick(5);
    rx_tvalid = 1'b0;
    tick(1);
    checkOutput("t4_lat5", 64'(latency_count), 64'd5);
    checkOutput("t4_max_kept", 64'(latency_max), 64'd20);

    // Pending XOFF is not aborted by the level dropping.
    applyStimulus(10'd400, 1'b1, 1'b0, 1'b0);
    doReset();
    tick(1);
    fifo_rx_level = 10'd0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("t5_hold_tvalid", 64'(s_axi_nfc_tvalid), 64'd1);
      checkOutput("t5_hold_tdata", 64'(s_axi_nfc_tdata), 64'hFFFF);
    end
    s_axi_nfc_tready = 1'b1;
    tick(2);
    checkOutput("t5_xon_tvalid", 64'(s_axi_nfc_tvalid), 64'd1);
    checkOutput("t5_xon_tdata", 64'(s_axi_nfc_tdata), 64'h0000);
    tick(1);
    checkOutput("t5_full", 64'(full_trigger_count), 64'd1);
    checkOutput("t5_empty", 64'(empty_trigger_count), 64'd1);

    // Disabling while paused sends XON and suppresses further XOFF.
    applyStimulus(10'd400, 1'b1, 1'b0, 1'b1);
    doReset();
    tick(2);
    enable = 1'b0;
    tick(1);
    checkOutput("t6_xon_tvalid", 64'(s_axi_nfc_tvalid), 64'd1);
    checkOutput("t6_xon_tdata", 64'(s_axi_nfc_tdata), 64'h0000);
    tick(1);
    checkOutput("t6_empty", 64'(empty_trigger_count), 64'd1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checkOutput("t6_idle_tvalid", 64'(s_axi_nfc_tvalid), 64'd0);
    end
    checkOutput("t6_full", 64'(full_trigger_count), 64'd1);
    checkOutput("t6_paused", 64'(paused), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
